// File: rtl/ppa_pkg.sv
// ppa_pkg: shared types, topology constants and prefix-network helpers for the pipelined adder
package ppa_pkg;
  localparam int TOPO_SKLANSKY = 0;
  localparam int TOPO_KOGGE = 1;
  typedef struct packed {
    logic g;
    logic p;
  } ppa_gp_t;
  function automatic int ppa_levels(input int width);
    return $clog2(width + 1);
  endfunction
  function automatic int ppa_span(input int topo, input int lvl, input int i);
    if (topo == TOPO_KOGGE) return i >= (1 << lvl) ? i - (1 << lvl) : -1;
    return ((i >> lvl) & 1) != 0 ? ((i >> lvl) << lvl) - 1 : -1;
  endfunction
endpackage

// File: rtl/ppa_prefix_level.sv
// ppa_prefix_level: one combinational row of black/grey prefix cells over positions -1..WIDTH-1
module ppa_prefix_level
  import ppa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TOPOLOGY = TOPO_SKLANSKY,
  parameter int LEVEL = 0
) (
  input  ppa_gp_t [WIDTH:0] gp_i,
  output ppa_gp_t [WIDTH:0] gp_o
);
  for (genvar j = 0; j <= WIDTH; j++) begin : g_cell
    localparam int SRC = ppa_span(TOPOLOGY, LEVEL, j);
    if (SRC < 0) begin : g_pass
      assign gp_o[j] = gp_i[j];
    end else begin : g_op
      assign gp_o[j].g = gp_i[j].g | (gp_i[j].p & gp_i[SRC].g);
      assign gp_o[j].p = (j >= (2 << LEVEL)) && gp_i[j].p && gp_i[SRC].p;
    end
  end
endmodule

// File: rtl/ppa_pipe_adder.sv
// ppa_pipe_adder: pipelined parallel-prefix adder with valid/ready; PPA_PIPE_OVF_EN adds signed-overflow port ovf
module ppa_pipe_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TOPOLOGY = TOPO_SKLANSKY,
  parameter int unsigned LVL_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PPA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int LVLS = ppa_levels(WIDTH);
  function automatic int nreg(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (LVL_REG[i]) c++;
    return c;
  endfunction
  localparam int S = 2 + nreg(LVLS);
  logic [S-1:0] v_q, v_d, en, vin, ld;
  logic all_v;
  ppa_gp_t [WIDTH:0] pre_d, pre_q;
  ppa_gp_t [WIDTH:0] gp_w [LVLS+1];
  ppa_gp_t [WIDTH:0] gp_c [LVLS];
  logic [WIDTH-1:0] pw [LVLS+1];
  logic [WIDTH-1:0] sum_d, sum_q;
  logic cout_d, cout_q;
  always_comb begin
    all_v = 1'b1;
    en = '0;
    for (int k = S - 1; k >= 0; k--) begin
      all_v = all_v & v_q[k];
      en[k] = !all_v || out_ready;
    end
  end
  assign vin = {v_q[S-2:0], in_valid};
  assign ld = en & vin;
  assign v_d = ld | (v_q & ~en);
  assign in_ready = en[0];
  assign out_valid = v_q[S-1];
  always_ff @(posedge clk) v_q <= rst ? '0 : v_d;
  assign pre_d[0] = '{g: cin, p: 1'b0};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign pre_d[i+1] = '{g: a[i] & b[i], p: a[i] ^ b[i]};
    assign pw[0][i] = pre_q[i+1].p;
    assign sum_d[i] = pw[LVLS][i] ^ gp_w[LVLS][i].g;
  end
  always_ff @(posedge clk) if (ld[0]) pre_q <= pre_d;
  assign gp_w[0] = pre_q;
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    ppa_prefix_level #(.WIDTH(WIDTH), .TOPOLOGY(TOPOLOGY), .LEVEL(l)) u_level (
      .gp_i(gp_w[l]),
      .gp_o(gp_c[l])
    );
    if (LVL_REG[l]) begin : g_reg
      localparam int K = 1 + nreg(l);
      ppa_gp_t [WIDTH:0] gp_q;
      logic [WIDTH-1:0] p_q;
      always_ff @(posedge clk)
        if (ld[K]) begin
          gp_q <= gp_c[l];
          p_q <= pw[l];
        end
      assign gp_w[l+1] = gp_q;
      assign pw[l+1] = p_q;
    end else begin : g_thru
      assign gp_w[l+1] = gp_c[l];
      assign pw[l+1] = pw[l];
    end
  end
  assign cout_d = gp_w[LVLS][WIDTH].g;
  always_ff @(posedge clk)
    if (rst) begin
      sum_q <= '0;
      cout_q <= 1'b0;
    end else if (ld[S-1]) begin
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  assign sum = sum_q;
  assign cout = cout_q;
`ifdef PPA_PIPE_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (ld[S-1]) ovf_q <= cout_d ^ gp_w[LVLS][WIDTH-1].g;
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ppa_pipe_adder.sv
// tb_ppa_pipe_adder: three adder configurations checked against an arithmetic scoreboard plus directed vectors
module tb_ppa_pipe_adder;
  typedef struct {
    logic [63:0] s;
    logic c;
    logic o;
    int t;
  } exp_t;
  typedef struct {
    int d;
    logic [63:0] a;
    logic [63:0] b;
    logic ci;
    logic [63:0] s;
    logic c;
    logic o;
  } vec_t;
  localparam int W [3] = '{16, 32, 64};
  localparam int LAT [3] = '{2, 4, 6};
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cin = 0, chk_lat = 0;
  logic [63:0] a = 0, b = 0;
  logic [2:0] in_ready, out_valid, cout, ovf;
  logic [15:0] s0;
  logic [31:0] s1;
  logic [63:0] sum_x [3];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int acc [3];
  int qn [3];
  vec_t tv [8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sum_x[0] = {48'b0, s0};
  assign sum_x[1] = {32'b0, s1};
  ppa_pipe_adder #(.WIDTH(16), .TOPOLOGY(0), .LVL_REG(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready), .sum(s0), .cout(cout[0])
`ifdef PPA_PIPE_OVF_EN
    , .ovf(ovf[0])
`endif
  );
  ppa_pipe_adder #(.WIDTH(32), .TOPOLOGY(1), .LVL_REG(5)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready), .sum(s1), .cout(cout[1])
`ifdef PPA_PIPE_OVF_EN
    , .ovf(ovf[1])
`endif
  );
  ppa_pipe_adder #(.WIDTH(64), .TOPOLOGY(0), .LVL_REG(85)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sum_x[2]), .cout(cout[2])
`ifdef PPA_PIPE_OVF_EN
    , .ovf(ovf[2])
`endif
  );
`ifndef PPA_PIPE_OVF_EN
  assign ovf = '0;
`endif
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c, input int w);
    exp_t e;
    logic [64:0] m, t;
    m = (65'd1 << w) - 65'd1;
    t = ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, c};
    e.s = t[63:0] & m[63:0];
    e.c = t[w];
    e.o = (x[w-1] == y[w-1]) && (e.s[w-1] != x[w-1]);
    e.t = 0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", nm, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rnd();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom);
  endtask
  for (genvar d = 0; d < 3; d++) begin : g_mon
    exp_t q [$];
    logic [63:0] held;
    bit hv = 0;
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        hv = 0;
      end else begin
        if (hv) begin
          chk($sformatf("dut%0d_hold_valid", d), 64'(out_valid[d]), 64'd1);
          chk($sformatf("dut%0d_hold_sum", d), sum_x[d], held);
        end
        hv = out_valid[d] && !out_ready;
        held = sum_x[d];
        if (out_valid[d] && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_extra: got result %h, need no beat", d, sum_x[d]);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("dut%0d_sum", d), sum_x[d], e.s);
            chk($sformatf("dut%0d_cout", d), 64'(cout[d]), 64'(e.c));
`ifdef PPA_PIPE_OVF_EN
            chk($sformatf("dut%0d_ovf", d), 64'(ovf[d]), 64'(e.o));
`endif
            if (chk_lat) chk($sformatf("dut%0d_latency", d), 64'(cyc - e.t), 64'(LAT[d]));
          end
        end
        if (in_valid && in_ready[d]) begin
          exp_t n;
          n = model(a, b, cin, W[d]);
          n.t = cyc;
          q.push_back(n);
          acc[d]++;
        end
        if (chk_lat) chk($sformatf("dut%0d_in_ready", d), 64'(in_ready[d]), 64'd1);
      end
      qn[d] = q.size();
    end
  end
  initial begin
    tv[0] = '{0, 64'hFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tv[1] = '{2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tv[2] = '{1, 64'hFFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    tv[3] = '{1, 64'h7FFF_FFFF, 64'h1, 1'b0, 64'h8000_0000, 1'b0, 1'b1};
    tv[4] = '{0, 64'h8000, 64'h8000, 1'b0, 64'h0, 1'b1, 1'b1};
    tv[5] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tv[6] = '{0, 64'h1234, 64'h4321, 1'b1, 64'h5556, 1'b0, 1'b0};
    tv[7] = '{1, 64'h0F0F_0F0F, 64'hF0F0_F0F0, 1'b1, 64'h0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) acc[k] = 0;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd7);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_sum%0d", k), sum_x[k], 64'd0);
    rst = 0;
    for (int v = 0; v < 8; v++) begin
      int lat;
      lat = 0;
      a = tv[v].a;
      b = tv[v].b;
      cin = tv[v].ci;
      in_valid = 1;
      step();
      in_valid = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge clk);
        if (out_valid[tv[v].d]) lat = k;
      end
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(LAT[tv[v].d]));
      chk($sformatf("vec%0d_sum", v), sum_x[tv[v].d], tv[v].s);
      chk($sformatf("vec%0d_cout", v), 64'(cout[tv[v].d]), 64'(tv[v].c));
`ifdef PPA_PIPE_OVF_EN
      chk($sformatf("vec%0d_ovf", v), 64'(ovf[tv[v].d]), 64'(tv[v].o));
`endif
      repeat (8) step();
    end
    chk_lat = 1;
    for (int i = 0; i < 100; i++) begin
      rnd();
      in_valid = 1;
      step();
    end
    in_valid = 0;
    repeat (8) step();
    chk_lat = 0;
    for (int k = 0; k < 3; k++) acc[k] = 0;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      rnd();
      step();
    end
    for (int k = 0; k < 3; k++) chk($sformatf("fill_depth%0d", k), 64'(acc[k]), 64'(LAT[k]));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    @(negedge clk);
    chk("full_passthru", 64'(in_ready), 64'd7);
    for (int i = 0; i < 20; i++) begin
      step();
      rnd();
      in_valid = 1'($urandom);
    end
    step();
    in_valid = 0;
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      rnd();
      in_valid = 1;
      step();
    end
    in_valid = 0;
    rst = 1;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd7);
    chk("midrst_cout", 64'(cout), 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("midrst_sum%0d", k), sum_x[k], 64'd0);
    rst = 0;
    repeat (10) step();
    for (int i = 0; i < 60; i++) begin
      rnd();
      in_valid = (i % 2 == 0);
      out_ready = (i % 2 == 1);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) step();
    for (int i = 0; i < 300; i++) begin
      rnd();
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (12) step();
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("drain_queue%0d", k), 64'(qn[k]), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
